// File: rtl/isqrt_unit.sv
// Multi-cycle unsigned integer square root, one root bit per clock.
// Optional round-to-nearest on the root; remainder is always the floor remainder.
module isqrt_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     Operand,
  input  logic                 Round,
  output logic [WIDTH/2-1:0]   Root,
  output logic [WIDTH/2:0]     Remainder,
  output logic                 Busy,
  output logic                 Ack
);

  localparam int RW = WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RW - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RND,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_op;
  logic             r_rnd;
  logic [RW-1:0]    r_acc;
  logic [RW+1:0]    r_rem;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_root;
  logic [RW:0]      r_remq;

  logic             w_accept;
  logic             w_calc;
  logic             w_rnd_step;
  logic [RW+1:0]    w_shift;
  logic [RW+1:0]    w_trial;
  logic [RW+1:0]    w_diff;
  logic             w_ge;
  logic [RW-1:0]    w_acc_nxt;
  logic             w_up;
  logic             w_sat;
  logic [RW-1:0]    w_root_fin;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_calc      = 1'b0;
    w_rnd_step  = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        if (Start) begin
          w_accept    = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_calc = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = RND;
        end
      end
      RND: begin
        w_rnd_step  = 1'b1;
        w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Restoring step: bring down two radicand bits, try {root,01}
  always_comb begin
    w_shift   = {r_rem[RW-1:0], r_op[WIDTH-1 -: 2]};
    w_trial   = {r_acc, 2'b01};
    w_ge      = (w_shift >= w_trial);
    w_diff    = w_shift - w_trial;
    w_acc_nxt = {r_acc[RW-2:0], w_ge};
  end

  // Round up only when the remainder exceeds root, i.e. N > r*r + r
  always_comb begin
    w_sat      = &r_acc;
    w_up       = r_rnd && (r_rem > {2'b00, r_acc});
    w_root_fin = (w_up && !w_sat) ? (r_acc + 1'b1) : r_acc;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op  <= '0;
      r_rnd <= 1'b0;
      r_acc <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= Operand;
      r_rnd <= Round;
      r_acc <= '0;
      r_rem <= '0;
      r_cnt <= CNT_INIT;
    end else if (w_calc) begin
      r_op  <= r_op << 2;
      r_acc <= w_acc_nxt;
      r_rem <= w_ge ? w_diff : w_shift;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Result registers change only when a new result is resolved
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_root <= '0;
      r_remq <= '0;
    end else if (w_rnd_step) begin
      r_root <= w_root_fin;
      r_remq <= r_rem[RW:0];
    end
  end

  assign Root      = r_root;
  assign Remainder = r_remq;
  assign Busy      = (r_state == CALC) || (r_state == RND);
  assign Ack       = (r_state == DONE);

endmodule

// File: tb/tb_isqrt_unit.sv
// Directed bench for isqrt_unit: WIDTH=16 scenarios plus a WIDTH=8 sweep.
// Every task starts and ends 1 time unit after a rising clock edge.
module tb_isqrt_unit;

  logic        clk;
  logic        rst;

  logic        st16;
  logic [15:0] op16;
  logic        rd16;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  logic        busy16;
  logic        ack16;

  logic        st8;
  logic [7:0]  op8;
  logic        rd8;
  logic [3:0]  root8;
  logic [4:0]  rem8;
  logic        busy8;
  logic        ack8;

  int vecs;
  int errs;

  isqrt_unit #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset(rst), .Start(st16), .Operand(op16),
    .Round(rd16), .Root(root16), .Remainder(rem16),
    .Busy(busy16), .Ack(ack16)
  );

  isqrt_unit #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(rst), .Start(st8), .Operand(op8),
    .Round(rd8), .Root(root8), .Remainder(rem8),
    .Busy(busy8), .Ack(ack8)
  );

  always #5 clk = ~clk;

  task automatic run16(input logic [15:0] op, input logic rnd,
                       output logic [7:0] r, output logic [8:0] m,
                       output int lat);
    st16 = 1'b1;
    op16 = op;
    rd16 = rnd;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    lat  = 0;
    while (!ack16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = root16;
    m = rem16;
  endtask

  task automatic run8(input logic [7:0] op, input logic rnd,
                      output logic [3:0] r, output logic [4:0] m,
                      output int lat);
    st8 = 1'b1;
    op8 = op;
    rd8 = rnd;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    lat = 0;
    while (!ack8 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = root8;
    m = rem8;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    vecs++;
    if ({root16, rem16, busy16, ack16} !== 19'd0) begin
      errs++;
      $display("FAIL reset16: got root=%0d rem=%0d busy=%b ack=%b want all 0",
               root16, rem16, busy16, ack16);
    end
    vecs++;
    if ({root8, rem8, busy8, ack8} !== 11'd0) begin
      errs++;
      $display("FAIL reset8: got root=%0d rem=%0d busy=%b ack=%b want all 0",
               root8, rem8, busy8, ack8);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [7:0] r;
    logic [8:0] m;
    int lat;
    rst = 1'b0;
    run16(16'd36864, 1'b0, r, m, lat);
    vecs++;
    if (r !== 8'd192 || m !== 9'd0 || lat != 9) begin
      errs++;
      $display("FAIL basic_36864: got root=%0d rem=%0d lat=%0d want 192 0 9",
               r, m, lat);
    end
  endtask

  task automatic test_max;
    logic [7:0] r;
    logic [8:0] m;
    int lat;
    run16(16'hFFFF, 1'b0, r, m, lat);
    vecs++;
    if (r !== 8'd255 || m !== 9'd510 || lat != 9) begin
      errs++;
      $display("FAIL max_floor: got root=%0d rem=%0d lat=%0d want 255 510 9",
               r, m, lat);
    end
    run16(16'hFFFF, 1'b1, r, m, lat);
    vecs++;
    if (r !== 8'd255 || m !== 9'd510 || lat != 9) begin
      errs++;
      $display("FAIL max_round: got root=%0d rem=%0d lat=%0d want 255 510 9",
               r, m, lat);
    end
  endtask

  task automatic test_round_boundary;
    logic [7:0] r;
    logic [8:0] m;
    int lat;
    run16(16'd210, 1'b1, r, m, lat);
    vecs++;
    if (r !== 8'd14 || m !== 9'd14) begin
      errs++;
      $display("FAIL rnd_210: got root=%0d rem=%0d want 14 14", r, m);
    end
    st16 = 1'b1;
    op16 = 16'd211;
    rd16 = 1'b1;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if (root16 !== 8'd14 || rem16 !== 9'd14 || busy16 !== 1'b1
        || ack16 !== 1'b0) begin
      errs++;
      $display("FAIL hold_prev: got root=%0d rem=%0d busy=%b ack=%b want 14 14 1 0",
               root16, rem16, busy16, ack16);
    end
    lat = 2;
    while (!ack16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vecs++;
    if (root16 !== 8'd15 || rem16 !== 9'd15 || lat != 9) begin
      errs++;
      $display("FAIL rnd_211: got root=%0d rem=%0d lat=%0d want 15 15 9",
               root16, rem16, lat);
    end
    run16(16'd211, 1'b0, r, m, lat);
    vecs++;
    if (r !== 8'd14 || m !== 9'd15) begin
      errs++;
      $display("FAIL floor_211: got root=%0d rem=%0d want 14 15", r, m);
    end
  endtask

  task automatic test_reset_abort;
    logic [7:0] r;
    logic [8:0] m;
    int lat;
    int acks;
    st16 = 1'b1;
    op16 = 16'd40000;
    rd16 = 1'b0;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vecs++;
    if (root16 !== 8'd0 || rem16 !== 9'd0 || busy16 !== 1'b0
        || ack16 !== 1'b0) begin
      errs++;
      $display("FAIL async_rst: got root=%0d rem=%0d busy=%b ack=%b want 0 0 0 0",
               root16, rem16, busy16, ack16);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (ack16 || busy16) acks++;
    end
    vecs++;
    if (acks != 0) begin
      errs++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", acks);
    end
    run16(16'd40000, 1'b0, r, m, lat);
    vecs++;
    if (r !== 8'd200 || m !== 9'd0 || lat != 9) begin
      errs++;
      $display("FAIL after_abort: got root=%0d rem=%0d lat=%0d want 200 0 9",
               r, m, lat);
    end
  endtask

  task automatic test_zero_ignore;
    int lat;
    int bad;
    st16 = 1'b1;
    op16 = 16'd0;
    rd16 = 1'b0;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st16 = 1'b1;
    op16 = 16'd100;
    rd16 = 1'b1;
    @(posedge clk);
    #1;
    st16 = 1'b0;
    op16 = 16'd0;
    rd16 = 1'b0;
    lat  = 3;
    while (!ack16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vecs++;
    if (root16 !== 8'd0 || rem16 !== 9'd0 || lat != 9) begin
      errs++;
      $display("FAIL zero_ignore: got root=%0d rem=%0d lat=%0d want 0 0 9",
               root16, rem16, lat);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (ack16 !== 1'b1 || busy16 !== 1'b0 || root16 !== 8'd0
          || rem16 !== 9'd0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL done_hold: got %0d unstable cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int acks;
    int both;
    int badv;
    int lat;
    st16 = 1'b1;
    op16 = 16'd211;
    rd16 = 1'b0;
    @(posedge clk);
    acks = 0;
    both = 0;
    badv = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ack16) begin
        acks++;
        if (root16 !== 8'd14 || rem16 !== 9'd15) badv++;
      end
      if (ack16 && busy16) both++;
    end
    st16 = 1'b0;
    vecs++;
    if (acks != 4 || both != 0 || badv != 0) begin
      errs++;
      $display("FAIL back_to_back: got acks=%0d both=%0d bad=%0d want 4 0 0",
               acks, both, badv);
    end
    lat = 0;
    while (!ack16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    vecs++;
    if (lat != 9 || root16 !== 8'd14) begin
      errs++;
      $display("FAIL b2b_last: got lat=%0d root=%0d want 9 14", lat, root16);
    end
  endtask

  task automatic test_w8;
    logic [3:0] r;
    logic [4:0] m;
    int lat;
    run8(8'd255, 1'b0, r, m, lat);
    vecs++;
    if (r !== 4'd15 || m !== 5'd30 || lat != 5) begin
      errs++;
      $display("FAIL w8_255: got root=%0d rem=%0d lat=%0d want 15 30 5",
               r, m, lat);
    end
  endtask

  task automatic test_sweep8;
    logic [3:0] r;
    logic [4:0] m;
    int lat;
    int fr;
    int er;
    int em;
    for (int n = 0; n < 256; n++) begin
      for (int md = 0; md < 2; md++) begin
        fr = 0;
        while ((fr + 1) * (fr + 1) <= n) fr++;
        em = n - fr * fr;
        er = fr;
        if (md == 1 && em > fr && fr != 15) er = fr + 1;
        run8(n[7:0], md[0], r, m, lat);
        vecs++;
        if (int'(r) != er || int'(m) != em || lat != 5) begin
          errs++;
          $display("FAIL sweep8 n=%0d rnd=%0d: got root=%0d rem=%0d lat=%0d want %0d %0d 5",
                   n, md, r, m, lat, er, em);
        end
      end
    end
  endtask

  initial begin
    clk  = 1'b0;
    rst  = 1'b1;
    st16 = 1'b0;
    op16 = '0;
    rd16 = 1'b0;
    st8  = 1'b0;
    op8  = '0;
    rd8  = 1'b0;
    vecs = 0;
    errs = 0;
    @(posedge clk);
    #1;
    test_reset;
    test_basic;
    test_max;
    test_round_boundary;
    test_reset_abort;
    test_zero_ignore;
    test_back_to_back;
    test_w8;
    test_sweep8;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
